// File: rtl/ctrl_pkg.sv
// Shared opcode, control-encoding and state definitions for the instruction
// control sequencer and its combinational decoder.
package ctrl_pkg;

  // Full-word opcodes, including the first word of each two-word branch.
  localparam logic [15:0] OP_ABS  = 16'h7F88;
  localparam logic [15:0] OP_PAC  = 16'h7F8E;
  localparam logic [15:0] OP_APAC = 16'h7F8F;
  localparam logic [15:0] OP_SPAC = 16'h7F90;
  localparam logic [15:0] OP_B    = 16'hF900;
  localparam logic [15:0] OP_CALL = 16'hF800;
  localparam logic [15:0] OP_BANZ = 16'hF400;

  localparam logic [7:0] OP_ADDH = 8'h60;
  localparam logic [7:0] OP_ADDS = 8'h61;
  localparam logic [7:0] OP_LT   = 8'h6A;
  localparam logic [7:0] OP_LTA  = 8'h6C;
  localparam logic [7:0] OP_MPY  = 8'h6D;
  localparam logic [7:0] OP_LDP  = 8'h6F;
  localparam logic [7:0] OP_AND  = 8'h79;
  localparam logic [7:0] OP_OR   = 8'h7A;
  localparam logic [7:0] OP_LACK = 8'h7E;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_LAC = 4'h2;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_ABS  = 3'b100;
  localparam logic [2:0] ALU_PASS = 3'b101;

  localparam logic [2:0] ACC_HOLD  = 3'b000;
  localparam logic [2:0] ACC_ALU   = 3'b001;
  localparam logic [2:0] ACC_IMM   = 3'b010;
  localparam logic [2:0] ACC_SHIFT = 3'b011;
  localparam logic [2:0] ACC_HI16  = 3'b100;

  localparam logic [1:0] PC_INC    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_BANZ   = 2'b10;

  localparam logic [1:0] ALU_IN_DATA = 2'b00;
  localparam logic [1:0] ALU_IN_PROD = 2'b01;

  typedef enum logic {
    S_DECODE  = 1'b0,
    S_OPERAND = 1'b1
  } state_t;

  typedef struct packed {
    logic       mult_in_mux;
    logic [1:0] alu_in_mux;
    logic [2:0] accum_in_mux;
    logic       ar_in_mux;
    logic       data_mux;
    logic       data_ram_in;
    logic [1:0] pc_in_mux;
    logic       io_external_mux;
    logic [2:0] alu;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t CTRL_HOLD = '{
    mult_in_mux: 1'b0, alu_in_mux: ALU_IN_DATA, accum_in_mux: ACC_HOLD,
    ar_in_mux: 1'b0, data_mux: 1'b0, data_ram_in: 1'b0, pc_in_mux: PC_INC,
    io_external_mux: 1'b0, alu: ALU_ADD
  };

  // Bundle with only the accumulator source and ALU operation set.
  function automatic ctrl_bundle_t ctrl_acc_alu(input logic [2:0] acc,
                                                input logic [2:0] op);
    ctrl_bundle_t b;
    b              = CTRL_HOLD;
    b.accum_in_mux = acc;
    b.alu          = op;
    return b;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder: one 16-bit word in, unregistered control
// bundle plus immediate, two-word and illegal flags out.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int IMM_W = 8
) (
  input  logic [15:0]      instruction,
  output ctrl_bundle_t     ctrl,
  output logic [IMM_W-1:0] imm,
  output logic             two_word,
  output logic             illegal
);

  logic [IMM_W-1:0] dma_s;
  logic [IMM_W-1:0] lack_s;
  logic [IMM_W-1:0] page_s;

  assign dma_s  = IMM_W'(instruction[6:0]);
  assign lack_s = IMM_W'(instruction[7:0]);
  assign page_s = IMM_W'(instruction[0]);

  // Priority decode: exact word, then high byte, then high nibble.
  always_comb begin
    ctrl     = CTRL_HOLD;
    imm      = {IMM_W{1'b0}};
    two_word = 1'b0;
    illegal  = 1'b0;
    case (instruction)
      OP_ABS:  ctrl = ctrl_acc_alu(ACC_ALU, ALU_ABS);
      OP_APAC: begin
        ctrl            = ctrl_acc_alu(ACC_ALU, ALU_ADD);
        ctrl.alu_in_mux = ALU_IN_PROD;
      end
      OP_PAC: begin
        ctrl            = ctrl_acc_alu(ACC_ALU, ALU_PASS);
        ctrl.alu_in_mux = ALU_IN_PROD;
      end
      OP_SPAC: begin
        ctrl            = ctrl_acc_alu(ACC_ALU, ALU_SUB);
        ctrl.alu_in_mux = ALU_IN_PROD;
      end
      OP_B, OP_CALL: begin
        two_word       = 1'b1;
        ctrl.pc_in_mux = PC_BRANCH;
      end
      OP_BANZ: begin
        two_word       = 1'b1;
        ctrl.pc_in_mux = PC_BANZ;
      end
      default: begin
        case (instruction[15:8])
          OP_ADDH: begin
            ctrl = ctrl_acc_alu(ACC_HI16, ALU_ADD);
            imm  = dma_s;
          end
          OP_ADDS: begin
            ctrl = ctrl_acc_alu(ACC_SHIFT, ALU_ADD);
            imm  = dma_s;
          end
          OP_AND: begin
            ctrl = ctrl_acc_alu(ACC_ALU, ALU_AND);
            imm  = dma_s;
          end
          OP_OR: begin
            ctrl = ctrl_acc_alu(ACC_ALU, ALU_OR);
            imm  = dma_s;
          end
          OP_LACK: begin
            ctrl = ctrl_acc_alu(ACC_IMM, ALU_ADD);
            imm  = lack_s;
          end
          OP_LDP: imm = page_s;
          OP_LT: begin
            ctrl.mult_in_mux = 1'b1;
            imm              = dma_s;
          end
          OP_LTA: begin
            ctrl             = ctrl_acc_alu(ACC_ALU, ALU_ADD);
            ctrl.mult_in_mux = 1'b1;
            ctrl.alu_in_mux  = ALU_IN_PROD;
            imm              = dma_s;
          end
          OP_MPY: begin
            ctrl.data_mux = 1'b1;
            imm           = dma_s;
          end
          default: begin
            case (instruction[15:12])
              OP_ADD: begin
                ctrl = ctrl_acc_alu(ACC_SHIFT, ALU_ADD);
                imm  = dma_s;
              end
              OP_SUB: begin
                ctrl = ctrl_acc_alu(ACC_SHIFT, ALU_SUB);
                imm  = dma_s;
              end
              OP_LAC: begin
                ctrl = ctrl_acc_alu(ACC_SHIFT, ALU_PASS);
                imm  = dma_s;
              end
              default: illegal = 1'b1;
            endcase
          end
        endcase
      end
    endcase
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// Registered instruction control sequencer: valid/ready word intake, two-word
// branch assembly and a held control bundle for a stallable datapath.
module ctrl_sequencer
  import ctrl_pkg::*;
#(
  parameter int PC_W           = 12,
  parameter int IMM_W          = 8,
  parameter bit NOP_ON_ILLEGAL = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  input  logic [15:0]      instruction,
  output logic             instr_ready,
  input  logic             stall,
  output logic             ctrl_valid,
  output logic             multInMux_ctrl,
  output logic [1:0]       aluInMux_ctrl,
  output logic [2:0]       accumInMux_ctrl,
  output logic             arInMux_ctrl,
  output logic             dataMux_ctrl,
  output logic             dataRamIn_ctrl,
  output logic [1:0]       pcInMux_ctrl,
  output logic             ioExternalMux_ctrl,
  output logic [2:0]       alu_ctrl,
  output logic [IMM_W-1:0] imm,
  output logic [PC_W-1:0]  branch_target,
  output logic             illegal
);

  ctrl_bundle_t     dec_ctrl_s;
  logic [IMM_W-1:0] dec_imm_s;
  logic             dec_two_word_s;
  logic             dec_illegal_s;
  logic             accept_s;

  state_t           state_r;
  ctrl_bundle_t     ctrl_r;
  logic [IMM_W-1:0] imm_r;
  logic [PC_W-1:0]  branch_target_r;
  logic             illegal_r;
  logic             ctrl_valid_r;
  ctrl_bundle_t     pend_ctrl_r;
  logic [IMM_W-1:0] pend_imm_r;

  ctrl_decode #(
    .IMM_W(IMM_W)
  ) u_decode (
    .instruction(instruction),
    .ctrl       (dec_ctrl_s),
    .imm        (dec_imm_s),
    .two_word   (dec_two_word_s),
    .illegal    (dec_illegal_s)
  );

  // A held bundle blocks intake; a consumed or empty slot can refill this cycle.
  assign instr_ready = ~ctrl_valid_r | ~stall;
  assign accept_s    = instr_valid & instr_ready;

  assign ctrl_valid         = ctrl_valid_r;
  assign multInMux_ctrl     = ctrl_r.mult_in_mux;
  assign aluInMux_ctrl      = ctrl_r.alu_in_mux;
  assign accumInMux_ctrl    = ctrl_r.accum_in_mux;
  assign arInMux_ctrl       = ctrl_r.ar_in_mux;
  assign dataMux_ctrl       = ctrl_r.data_mux;
  assign dataRamIn_ctrl     = ctrl_r.data_ram_in;
  assign pcInMux_ctrl       = ctrl_r.pc_in_mux;
  assign ioExternalMux_ctrl = ctrl_r.io_external_mux;
  assign alu_ctrl           = ctrl_r.alu;
  assign imm                = imm_r;
  assign branch_target      = branch_target_r;
  assign illegal            = illegal_r;

  // Sequencer FSM and output bundle registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r         <= S_DECODE;
      ctrl_r          <= CTRL_HOLD;
      imm_r           <= {IMM_W{1'b0}};
      branch_target_r <= {PC_W{1'b0}};
      illegal_r       <= 1'b0;
      ctrl_valid_r    <= 1'b0;
      pend_ctrl_r     <= CTRL_HOLD;
      pend_imm_r      <= {IMM_W{1'b0}};
    end else if (accept_s) begin
      case (state_r)
        S_DECODE: begin
          if (dec_two_word_s || (dec_illegal_s && !NOP_ON_ILLEGAL)) begin
            // First branch word or a silently dropped opcode: nothing issues.
            ctrl_r          <= CTRL_HOLD;
            imm_r           <= {IMM_W{1'b0}};
            branch_target_r <= {PC_W{1'b0}};
            illegal_r       <= 1'b0;
            ctrl_valid_r    <= 1'b0;
            if (dec_two_word_s) begin
              pend_ctrl_r <= dec_ctrl_s;
              pend_imm_r  <= dec_imm_s;
              state_r     <= S_OPERAND;
            end else begin
              state_r <= S_DECODE;
            end
          end else begin
            ctrl_r          <= dec_ctrl_s;
            imm_r           <= dec_imm_s;
            branch_target_r <= {PC_W{1'b0}};
            illegal_r       <= dec_illegal_s;
            ctrl_valid_r    <= 1'b1;
            state_r         <= S_DECODE;
          end
        end
        S_OPERAND: begin
          ctrl_r          <= pend_ctrl_r;
          imm_r           <= pend_imm_r;
          branch_target_r <= instruction[PC_W-1:0];
          illegal_r       <= 1'b0;
          ctrl_valid_r    <= 1'b1;
          state_r         <= S_DECODE;
        end
        default: begin
          ctrl_r          <= CTRL_HOLD;
          imm_r           <= {IMM_W{1'b0}};
          branch_target_r <= {PC_W{1'b0}};
          illegal_r       <= 1'b0;
          ctrl_valid_r    <= 1'b0;
          state_r         <= S_DECODE;
        end
      endcase
    end else if (ctrl_valid_r && !stall) begin
      ctrl_r          <= CTRL_HOLD;
      imm_r           <= {IMM_W{1'b0}};
      branch_target_r <= {PC_W{1'b0}};
      illegal_r       <= 1'b0;
      ctrl_valid_r    <= 1'b0;
    end else begin
      ctrl_valid_r <= ctrl_valid_r;
    end
  end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Self-checking bench for ctrl_sequencer: directed vector table, multi-cycle
// corner sequences and randomized traffic against a mnemonic-level model.
module tb_ctrl_sequencer;

  typedef struct packed {
    logic        cv;
    logic        mult;
    logic [1:0]  aluin;
    logic [2:0]  accum;
    logic        ar;
    logic        dmux;
    logic        dram;
    logic [1:0]  pc;
    logic        io;
    logic [2:0]  alu;
    logic [7:0]  imm;
    logic [11:0] bt;
    logic        ill;
  } exp_t;

  typedef struct {
    logic        v;
    logic [15:0] w;
    logic        s;
    logic        rdy;
    exp_t        e;
    string       name;
  } vec_t;

  localparam exp_t ZERO = '0;

  logic clk = 1'b0;
  logic reset;
  logic instr_valid;
  logic [15:0] instruction;
  logic stall;

  logic rdy1, cv1, mult1, ar1, dmux1, dram1, io1, ill1;
  logic [1:0] aluin1, pc1;
  logic [2:0] accum1, alu1;
  logic [7:0] imm1;
  logic [11:0] bt1;
  logic rdy0, cv0, mult0, ar0, dmux0, dram0, io0, ill0;
  logic [1:0] aluin0, pc0;
  logic [2:0] accum0, alu0;
  logic [7:0] imm0;
  logic [11:0] bt0;

  exp_t act1, act0;
  assign act1 = {cv1, mult1, aluin1, accum1, ar1, dmux1, dram1, pc1, io1, alu1, imm1, bt1, ill1};
  assign act0 = {cv0, mult0, aluin0, accum0, ar0, dmux0, dram0, pc0, io0, alu0, imm0, bt0, ill0};

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  ctrl_sequencer #(.PC_W(12), .IMM_W(8), .NOP_ON_ILLEGAL(1'b1)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instruction(instruction),
    .instr_ready(rdy1), .stall(stall), .ctrl_valid(cv1), .multInMux_ctrl(mult1),
    .aluInMux_ctrl(aluin1), .accumInMux_ctrl(accum1), .arInMux_ctrl(ar1),
    .dataMux_ctrl(dmux1), .dataRamIn_ctrl(dram1), .pcInMux_ctrl(pc1),
    .ioExternalMux_ctrl(io1), .alu_ctrl(alu1), .imm(imm1), .branch_target(bt1),
    .illegal(ill1)
  );

  ctrl_sequencer #(.PC_W(12), .IMM_W(8), .NOP_ON_ILLEGAL(1'b0)) dut_drop (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instruction(instruction),
    .instr_ready(rdy0), .stall(stall), .ctrl_valid(cv0), .multInMux_ctrl(mult0),
    .aluInMux_ctrl(aluin0), .accumInMux_ctrl(accum0), .arInMux_ctrl(ar0),
    .dataMux_ctrl(dmux0), .dataRamIn_ctrl(dram0), .pcInMux_ctrl(pc0),
    .ioExternalMux_ctrl(io0), .alu_ctrl(alu0), .imm(imm0), .branch_target(bt0),
    .illegal(ill0)
  );

  task automatic chk(input string name, input logic [36:0] act, input logic [36:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic exp_t mk(input logic [2:0] accum, input logic [2:0] alu,
                              input logic [1:0] aluin, input logic mult,
                              input logic dmux, input logic [1:0] pc,
                              input logic [7:0] imm, input logic [11:0] bt);
    exp_t e = '0;
    e.cv = 1'b1; e.accum = accum; e.alu = alu; e.aluin = aluin; e.mult = mult;
    e.dmux = dmux; e.pc = pc; e.imm = imm; e.bt = bt;
    return e;
  endfunction

  // Drive one cycle, check readiness before the edge and the bundle after it.
  task automatic cycle(input logic v, input logic [15:0] w, input logic s,
                       input logic exp_rdy, input exp_t e, input string name);
    instr_valid = v; instruction = w; stall = s;
    #1;
    chk({name, ".ready"}, {36'd0, rdy1}, {36'd0, exp_rdy});
    @(posedge clk); #1;
    chk(name, act1, e);
  endtask

  function automatic string op_of(input logic [15:0] w);
    if (w == 16'hF900) return "B";
    if (w == 16'hF800) return "CALL";
    if (w == 16'hF400) return "BANZ";
    if (w == 16'h7F88) return "ABS";
    if (w == 16'h7F8F) return "APAC";
    if (w == 16'h7F8E) return "PAC";
    if (w == 16'h7F90) return "SPAC";
    if (w[15:8] == 8'h60) return "ADDH";
    if (w[15:8] == 8'h61) return "ADDS";
    if (w[15:8] == 8'h6A) return "LT";
    if (w[15:8] == 8'h6C) return "LTA";
    if (w[15:8] == 8'h6D) return "MPY";
    if (w[15:8] == 8'h6F) return "LDP";
    if (w[15:8] == 8'h79) return "AND";
    if (w[15:8] == 8'h7A) return "OR";
    if (w[15:8] == 8'h7E) return "LACK";
    if (w[15:12] == 4'h0) return "ADD";
    if (w[15:12] == 4'h1) return "SUB";
    if (w[15:12] == 4'h2) return "LAC";
    return "ILL";
  endfunction

  function automatic exp_t fields_of(input string op, input logic [15:0] w);
    logic [7:0] dma;
    dma = {1'b0, w[6:0]};
    if (op == "ADD" || op == "ADDS") return mk(3'd3, 3'd0, 2'd0, 1'b0, 1'b0, 2'd0, dma, 12'd0);
    if (op == "SUB")  return mk(3'd3, 3'd1, 2'd0, 1'b0, 1'b0, 2'd0, dma, 12'd0);
    if (op == "LAC")  return mk(3'd3, 3'd5, 2'd0, 1'b0, 1'b0, 2'd0, dma, 12'd0);
    if (op == "ADDH") return mk(3'd4, 3'd0, 2'd0, 1'b0, 1'b0, 2'd0, dma, 12'd0);
    if (op == "AND")  return mk(3'd1, 3'd2, 2'd0, 1'b0, 1'b0, 2'd0, dma, 12'd0);
    if (op == "OR")   return mk(3'd1, 3'd3, 2'd0, 1'b0, 1'b0, 2'd0, dma, 12'd0);
    if (op == "ABS")  return mk(3'd1, 3'd4, 2'd0, 1'b0, 1'b0, 2'd0, 8'd0, 12'd0);
    if (op == "LACK") return mk(3'd2, 3'd0, 2'd0, 1'b0, 1'b0, 2'd0, w[7:0], 12'd0);
    if (op == "LDP")  return mk(3'd0, 3'd0, 2'd0, 1'b0, 1'b0, 2'd0, {7'd0, w[0]}, 12'd0);
    if (op == "LT")   return mk(3'd0, 3'd0, 2'd0, 1'b1, 1'b0, 2'd0, dma, 12'd0);
    if (op == "LTA")  return mk(3'd1, 3'd0, 2'd1, 1'b1, 1'b0, 2'd0, dma, 12'd0);
    if (op == "MPY")  return mk(3'd0, 3'd0, 2'd0, 1'b0, 1'b1, 2'd0, dma, 12'd0);
    if (op == "APAC") return mk(3'd1, 3'd0, 2'd1, 1'b0, 1'b0, 2'd0, 8'd0, 12'd0);
    if (op == "SPAC") return mk(3'd1, 3'd1, 2'd1, 1'b0, 1'b0, 2'd0, 8'd0, 12'd0);
    if (op == "PAC")  return mk(3'd1, 3'd5, 2'd1, 1'b0, 1'b0, 2'd0, 8'd0, 12'd0);
    if (op == "BANZ") return mk(3'd0, 3'd0, 2'd0, 1'b0, 1'b0, 2'd2, 8'd0, 12'd0);
    return mk(3'd0, 3'd0, 2'd0, 1'b0, 1'b0, 2'd1, 8'd0, 12'd0);
  endfunction

  function automatic logic [15:0] rand_word();
    logic [15:0] r;
    r = 16'($urandom);
    case ($urandom_range(0, 17))
      0:  return {4'h0, r[11:0]};
      1:  return {4'h1, r[11:0]};
      2:  return {4'h2, r[11:0]};
      3:  return {8'h60, r[7:0]};
      4:  return {8'h61, r[7:0]};
      5:  return {8'h79, r[7:0]};
      6:  return {8'h7A, r[7:0]};
      7:  return {8'h7E, r[7:0]};
      8:  return {8'h6F, r[7:0]};
      9:  return {8'h6A, r[7:0]};
      10: return {8'h6C, r[7:0]};
      11: return {8'h6D, r[7:0]};
      12: return 16'h7F88;
      13: return 16'h7F8F;
      14: return 16'h7F8E;
      15: return 16'h7F90;
      16: return (r[0]) ? 16'hF900 : ((r[1]) ? 16'hF800 : 16'hF400);
      default: return r;
    endcase
  endfunction

  vec_t vecs[$];
  exp_t m_out, m_pend;
  bit   m_pending;

  initial begin
    reset = 1'b1; instr_valid = 1'b0; instruction = 16'h0000; stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.bundle", act1, ZERO);
    chk("reset.ready", {36'd0, rdy1}, 37'd1);
    reset = 1'b0;

    // Reset while waiting for a branch operand must abandon the branch.
    cycle(1'b1, 16'hF900, 1'b0, 1'b1, ZERO, "rst_mid.first");
    instr_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_mid.bundle", act1, ZERO);
    chk("rst_mid.ready", {36'd0, rdy1}, 37'd1);
    @(posedge clk); #1;
    chk("rst_mid.held", act1, ZERO);
    reset = 1'b0;
    cycle(1'b1, 16'h0123, 1'b0, 1'b1, mk(3'd3, 3'd0, 2'd0, 1'b0, 1'b0, 2'd0, 8'h23, 12'd0), "rst_mid.add");
    cycle(1'b0, 16'h0000, 1'b0, 1'b1, ZERO, "rst_mid.drain");

    vecs.push_back('{1'b1, 16'h0123, 1'b0, 1'b1, mk(3'd3, 3'd0, 2'd0, 1'b0, 1'b0, 2'd0, 8'h23, 12'd0), "add"});
    vecs.push_back('{1'b1, 16'h7E5A, 1'b0, 1'b1, mk(3'd2, 3'd0, 2'd0, 1'b0, 1'b0, 2'd0, 8'h5A, 12'd0), "lack"});
    vecs.push_back('{1'b1, 16'h7F90, 1'b0, 1'b1, mk(3'd1, 3'd1, 2'd1, 1'b0, 1'b0, 2'd0, 8'h00, 12'd0), "spac_b2b"});
    vecs.push_back('{1'b0, 16'h0000, 1'b0, 1'b1, ZERO, "drain"});
    vecs.push_back('{1'b1, 16'hF900, 1'b0, 1'b1, ZERO, "b.first"});
    vecs.push_back('{1'b1, 16'h0ABC, 1'b0, 1'b1, mk(3'd0, 3'd0, 2'd0, 1'b0, 1'b0, 2'd1, 8'h00, 12'hABC), "b.target"});
    vecs.push_back('{1'b1, 16'hF800, 1'b0, 1'b1, ZERO, "call.first"});
    vecs.push_back('{1'b1, 16'h0123, 1'b0, 1'b1, mk(3'd0, 3'd0, 2'd0, 1'b0, 1'b0, 2'd1, 8'h00, 12'h123), "call.target"});
    vecs.push_back('{1'b1, 16'hF400, 1'b0, 1'b1, ZERO, "banz.first"});
    vecs.push_back('{1'b1, 16'h0FFF, 1'b0, 1'b1, mk(3'd0, 3'd0, 2'd0, 1'b0, 1'b0, 2'd2, 8'h00, 12'hFFF), "banz.target"});
    vecs.push_back('{1'b1, 16'h6F01, 1'b0, 1'b1, mk(3'd0, 3'd0, 2'd0, 1'b0, 1'b0, 2'd0, 8'h01, 12'd0), "ldp"});
    vecs.push_back('{1'b1, 16'h6D45, 1'b0, 1'b1, mk(3'd0, 3'd0, 2'd0, 1'b0, 1'b1, 2'd0, 8'h45, 12'd0), "mpy"});
    vecs.push_back('{1'b1, 16'h6A7F, 1'b0, 1'b1, mk(3'd0, 3'd0, 2'd0, 1'b1, 1'b0, 2'd0, 8'h7F, 12'd0), "lt"});
    vecs.push_back('{1'b1, 16'h6C80, 1'b0, 1'b1, mk(3'd1, 3'd0, 2'd1, 1'b1, 1'b0, 2'd0, 8'h00, 12'd0), "lta"});
    vecs.push_back('{1'b1, 16'h60FF, 1'b0, 1'b1, mk(3'd4, 3'd0, 2'd0, 1'b0, 1'b0, 2'd0, 8'h7F, 12'd0), "addh"});
    vecs.push_back('{1'b1, 16'h6112, 1'b0, 1'b1, mk(3'd3, 3'd0, 2'd0, 1'b0, 1'b0, 2'd0, 8'h12, 12'd0), "adds"});
    vecs.push_back('{1'b1, 16'h7903, 1'b0, 1'b1, mk(3'd1, 3'd2, 2'd0, 1'b0, 1'b0, 2'd0, 8'h03, 12'd0), "and"});
    vecs.push_back('{1'b1, 16'h7A04, 1'b0, 1'b1, mk(3'd1, 3'd3, 2'd0, 1'b0, 1'b0, 2'd0, 8'h04, 12'd0), "or"});
    vecs.push_back('{1'b1, 16'h1F85, 1'b0, 1'b1, mk(3'd3, 3'd1, 2'd0, 1'b0, 1'b0, 2'd0, 8'h05, 12'd0), "sub"});
    vecs.push_back('{1'b1, 16'h2A11, 1'b0, 1'b1, mk(3'd3, 3'd5, 2'd0, 1'b0, 1'b0, 2'd0, 8'h11, 12'd0), "lac"});
    vecs.push_back('{1'b1, 16'h7F8E, 1'b0, 1'b1, mk(3'd1, 3'd5, 2'd1, 1'b0, 1'b0, 2'd0, 8'h00, 12'd0), "pac"});
    vecs.push_back('{1'b1, 16'h7F8F, 1'b0, 1'b1, mk(3'd1, 3'd0, 2'd1, 1'b0, 1'b0, 2'd0, 8'h00, 12'd0), "apac"});
    vecs.push_back('{1'b0, 16'h0000, 1'b0, 1'b1, ZERO, "drain2"});
    for (int i = 0; i < vecs.size(); i++)
      cycle(vecs[i].v, vecs[i].w, vecs[i].s, vecs[i].rdy, vecs[i].e, vecs[i].name);

    // ABS held under a 3-cycle stall while the next word waits.
    cycle(1'b1, 16'h7F88, 1'b0, 1'b1, mk(3'd1, 3'd4, 2'd0, 1'b0, 1'b0, 2'd0, 8'h00, 12'd0), "abs");
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 16'h0456, 1'b1, 1'b0, mk(3'd1, 3'd4, 2'd0, 1'b0, 1'b0, 2'd0, 8'h00, 12'd0), "abs.stall");
    cycle(1'b1, 16'h0456, 1'b0, 1'b1, mk(3'd3, 3'd0, 2'd0, 1'b0, 1'b0, 2'd0, 8'h56, 12'd0), "abs.release");
    cycle(1'b0, 16'h0000, 1'b0, 1'b1, ZERO, "abs.drain");

    // Undefined word: NOP bundle on one instance, silent drop on the other.
    begin
      exp_t e_ill;
      e_ill = ZERO; e_ill.cv = 1'b1; e_ill.ill = 1'b1;
      cycle(1'b1, 16'hFFFF, 1'b0, 1'b1, e_ill, "ill.nop");
      chk("ill.drop.bundle", act0, ZERO);
      instr_valid = 1'b0; stall = 1'b1;
      #1;
      chk("ill.drop.ready", {36'd0, rdy0}, 37'd1);
      chk("ill.nop.ready", {36'd0, rdy1}, 37'd0);
      @(posedge clk); #1;
      chk("ill.nop.held", act1, e_ill);
      chk("ill.drop.idle", act0, ZERO);
      cycle(1'b0, 16'h0000, 1'b0, 1'b1, ZERO, "ill.drain");
    end

    // Randomized traffic against the mnemonic-level model.
    m_out = ZERO; m_pend = ZERO; m_pending = 1'b0;
    for (int i = 0; i < 400; i++) begin
      logic v, s, r;
      logic [15:0] w;
      string op;
      v = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 2) == 0);
      w = rand_word();
      r = !m_out.cv || !s;
      if (v && r) begin
        if (m_pending) begin
          m_out = m_pend; m_out.bt = w[11:0]; m_pending = 1'b0;
        end else begin
          op = op_of(w);
          if (op == "B" || op == "CALL" || op == "BANZ") begin
            m_pend = fields_of(op, w); m_pending = 1'b1; m_out = ZERO;
          end else if (op == "ILL") begin
            m_out = ZERO; m_out.cv = 1'b1; m_out.ill = 1'b1;
          end else begin
            m_out = fields_of(op, w);
          end
        end
      end else if (m_out.cv && !s) begin
        m_out = ZERO;
      end
      cycle(v, w, s, r, m_out, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ctrl_sequencer.md
Name: ctrl_sequencer

Overview:
- Registered, multi-cycle successor to the combinational instruction control LUT.
- Accepts instruction words over a valid/ready handshake and decodes the full op set (ABS, ADD, ADDH, ADDS, AND, LAC, LACK, OR, SUB, LDP, LT, LTA, APAC, PAC, SPAC, MPY) plus the two-word branches B, BANZ and CALL.
- Emits one registered control bundle per instruction to the datapath; the bundle is held while the datapath stalls.

Parameters:
- PC_W, 12, width of program address and branch target.
- IMM_W, 8, width of short immediate (LACK constant, LDP page, 7-bit dma zero-extended).
- NOP_ON_ILLEGAL, 1, 1: undefined opcodes issue an all-zero bundle with illegal=1; 0: undefined opcodes are dropped silently.

Ports:
- clk, in, 1, system clock.
- reset, in, 1, asynchronous active-high reset.
- instr_valid, in, 1, instruction word present.
- instruction, in, 16, instruction word.
- instr_ready, out, 1, word accepted when instr_valid & instr_ready.
- stall, in, 1, datapath cannot consume the bundle this cycle.
- ctrl_valid, out, 1, bundle valid; consumed on ctrl_valid & ~stall.
- multInMux_ctrl, out, 1.
- aluInMux_ctrl, out, 2.
- accumInMux_ctrl, out, 3.
- arInMux_ctrl, out, 1.
- dataMux_ctrl, out, 1.
- dataRamIn_ctrl, out, 1.
- pcInMux_ctrl, out, 2.
- ioExternalMux_ctrl, out, 1.
- alu_ctrl, out, 3.
- imm, out, IMM_W, decoded immediate / dma.
- branch_target, out, PC_W, second word of a branch.
- illegal, out, 1, undefined opcode flag.

Behaviour:
Reset:
- State S_DECODE, instr_ready=1, ctrl_valid=0.
- All control outputs, imm, branch_target and illegal are 0.
- Reset asserted mid-instruction, including S_OPERAND, abandons the instruction with no partial bundle.

Decode priority: full 16-bit match, then bits[15:8], then bits[15:12]; first hit wins.

Encodings:
- alu_ctrl: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 ABS, 101 PASS.
- accumInMux_ctrl: 000 hold, 001 ALU, 010 imm, 011 data<<shift, 100 data<<16.
- pcInMux_ctrl: 00 PC+1, 01 branch_target, 10 BANZ conditional.

Per-op control:
- ADD: accum=011, alu=000.
- SUB: accum=011, alu=001.
- LAC: accum=011, alu=101.
- ADDH: accum=100, alu=000.
- ADDS: accum=011, alu=000, no sign extension.
- AND: accum=001, alu=010.
- OR: accum=001, alu=011.
- ABS: accum=001, alu=100.
- LACK: accum=010, imm=instruction[7:0].
- LDP: imm=instruction[0]; accumulator held.
- LT: multInMux_ctrl=1.
- LTA: multInMux_ctrl=1, accum=001, alu=000, aluInMux_ctrl=01.
- MPY: multInMux_ctrl=0, dataMux_ctrl=1.
- APAC: accum=001, alu=000, aluInMux_ctrl=01.
- SPAC: accum=001, alu=001, aluInMux_ctrl=01.
- PAC: accum=001, alu=101, aluInMux_ctrl=01.
- Branches: B=16'hF900, CALL=16'hF800, BANZ=16'hF400. B and CALL set pcInMux=01; BANZ sets pcInMux=10.
- For all direct-address ops, imm = instruction[6:0] zero-extended.

FSM:
- S_DECODE: instr_ready = ~ctrl_valid | ~stall. On accept:
  - Two-word op: latch decoded controls and go to S_OPERAND. ctrl_valid stays 0.
  - Otherwise: load the bundle and set ctrl_valid=1 on the next edge, giving 1-cycle latency.
- S_OPERAND: instr_ready = ~ctrl_valid | ~stall. The next accepted word loads branch_target=word[PC_W-1:0], raises ctrl_valid, and returns to S_DECODE.
- Hold: while ctrl_valid & stall, all outputs hold and instr_ready=0.
- Back-to-back: when ctrl_valid & ~stall and a new word is accepted the same cycle, the bundle is replaced with no bubble. Sustained throughput is one single-word instruction per clock.
- Drain: when ctrl_valid & ~stall and no word is accepted, ctrl_valid drops to 0 and the controls return to hold encodings.
- Illegal opcode: with NOP_ON_ILLEGAL=1, issue a bundle with all controls 0 and illegal=1. With NOP_ON_ILLEGAL=0, no bundle is issued.

Decomposition:
- Shared package ctrl_pkg holds:
  - All op encodings: the 16-, 8- and 4-bit opcodes plus branch words.
  - The alu_ctrl, accumInMux_ctrl and pcInMux_ctrl encoding constants.
  - The state encodings S_DECODE and S_OPERAND.
- One combinational sub-module ctrl_decode: instruction in, unregistered control bundle + two_word + illegal out.
- ctrl_sequencer holds the FSM, handshake and output registers.

Test Plan:
- Reset mid-S_OPERAND (after 16'hF900) -> next cycle ctrl_valid=0, instr_ready=1, all outputs 0; a following ADD still decodes normally.
- ADD 16'h0123, stall=0 -> 1 cycle later: ctrl_valid=1, accum=011, alu=000, imm=7'h23.
- LACK 16'h7E5A, then SPAC 16'h7F90 back-to-back -> consecutive bundles with no bubble:
  - first: accum=010, imm=8'h5A;
  - second: accum=001, alu=001, aluInMux=01.
- B 16'hF900, then 16'h0ABC -> no bundle after the first word; after the second word, ctrl_valid=1, pcInMux=01, branch_target=12'hABC.
- ABS 16'h7F88 with stall held 3 cycles -> bundle (accum=001, alu=100) stable for all 3 cycles, instr_ready=0; a word presented meanwhile is consumed only after stall drops.
- Undefined 16'hFFFF:
  - NOP_ON_ILLEGAL=1 -> illegal=1, all controls 0;
  - NOP_ON_ILLEGAL=0 -> ctrl_valid stays 0 and instr_ready stays 1.
